grid_writer: RTL

Write-side companion of the pixel-to-cell lookup on the VGA grid path. Accepts cursor and cell-edit commands over a valid/ready handshake, keeps a grid cursor, and issues single-cell or whole-grid write transactions to the grid RAM write port while the display path reads the other port. Also reports the cursor cell's pixel origin (cell → pixel, the inverse of the display lookup) for cursor overlay drawing.

---
 rtl/grid_pkg.sv | 15 +
 rtl/grid_writer_if.sv | 26 ++
 rtl/grid_to_pixel.sv | 13 +
 rtl/grid_writer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry, address widths, command/direction codes and writer states
package grid_pkg;
  localparam int GRID_W = 20;
  localparam int GRID_H = 20;
  localparam int CELL_W = 32;
  localparam int CELL_H = 17;
  localparam int ORG_X  = 112;
  localparam int ORG_Y  = 39;
  localparam int DATA_W = 4;
  localparam int AW     = 5;
  localparam int PW     = 11;
  typedef enum logic [1:0] {OP_SET, OP_MOVE, OP_WRITE, OP_FILL} op_e;
  typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_DOWN, DIR_UP} dir_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_FILL} state_e;
endpackage

// File: rtl/grid_writer_if.sv
// grid_writer_if: command channel (valid/ready) and grid RAM write channel (en/ready)
// master: command source / RAM side (drives cmd_*, wr_ready)
// slave : grid_writer side (drives cmd_ready, wr_en, wr_grid_x/y, wr_data)
interface grid_writer_if;
  import grid_pkg::*;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [AW-1:0]     cmd_x;
  logic [AW-1:0]     cmd_y;
  logic [1:0]        cmd_dir;
  logic [DATA_W-1:0] cmd_data;
  logic              wr_en;
  logic              wr_ready;
  logic [AW-1:0]     wr_grid_x;
  logic [AW-1:0]     wr_grid_y;
  logic [DATA_W-1:0] wr_data;
  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_dir, cmd_data, wr_ready,
    input  cmd_ready, wr_en, wr_grid_x, wr_grid_y, wr_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_dir, cmd_data, wr_ready,
    output cmd_ready, wr_en, wr_grid_x, wr_grid_y, wr_data
  );
endinterface

// File: rtl/grid_to_pixel.sv
// grid_to_pixel: combinational cell -> pixel-origin mapping
// i_grid_x/y: cell coordinates; o_pix_x/y: pixel of the cell's top-left corner
module grid_to_pixel
  import grid_pkg::*;
(
  input  logic [AW-1:0] i_grid_x,
  input  logic [AW-1:0] i_grid_y,
  output logic [PW-1:0] o_pix_x,
  output logic [PW-1:0] o_pix_y
);
  assign o_pix_x = PW'(ORG_X) + PW'(CELL_W) * PW'(i_grid_x);
  assign o_pix_y = PW'(ORG_Y) + PW'(CELL_H) * PW'(i_grid_y);
endmodule

// File: rtl/grid_writer.sv
// grid_writer: grid cursor plus single-cell / whole-grid writes to the grid RAM write port
// clk, rst_n    : clock, asynchronous active-low reset
// bus (slave)   : command channel in, grid RAM write channel out
// o_cur_grid_x/y: cursor cell; o_cur_pix_x/y: registered pixel origin of cursor cell
// o_fill_done   : one-cycle pulse after the last FILL write
// Optional: define GRID_FILL_EN to build the FILL sweep; otherwise op 3 is a no-op.
module grid_writer
  import grid_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  grid_writer_if.slave  bus,
  output logic [AW-1:0] o_cur_grid_x,
  output logic [AW-1:0] o_cur_grid_y,
  output logic [PW-1:0] o_cur_pix_x,
  output logic [PW-1:0] o_cur_pix_y,
  output logic          o_fill_done
);
  localparam logic [AW-1:0] XMAX = AW'(GRID_W - 1);
  localparam logic [AW-1:0] YMAX = AW'(GRID_H - 1);
  state_e            r_state, w_state;
  logic [AW-1:0]     r_cur_x, r_cur_y, w_cur_x, w_cur_y;
  logic [AW-1:0]     r_wr_x, r_wr_y, w_wr_x, w_wr_y;
  logic [DATA_W-1:0] r_wr_data, w_wr_data;
  logic              r_wr_en, w_wr_en;
  logic [PW-1:0]     r_pix_x, r_pix_y, w_pix_x, w_pix_y;
`ifdef GRID_FILL_EN
  logic              r_fill_done, w_fill_done;
`endif
  // pixel origin is computed from the next cursor so it lands on the same edge
  grid_to_pixel u_g2p (
    .i_grid_x (w_cur_x),
    .i_grid_y (w_cur_y),
    .o_pix_x  (w_pix_x),
    .o_pix_y  (w_pix_y)
  );
  always_comb begin
    w_state   = r_state;
    w_cur_x   = r_cur_x;
    w_cur_y   = r_cur_y;
    w_wr_en   = r_wr_en;
    w_wr_x    = r_wr_x;
    w_wr_y    = r_wr_y;
    w_wr_data = r_wr_data;
`ifdef GRID_FILL_EN
    w_fill_done = 1'b0;
`endif
    case (r_state)
      ST_IDLE: if (bus.cmd_valid) begin
        case (bus.cmd_op)
          OP_SET: begin
            w_cur_x = (bus.cmd_x > XMAX) ? XMAX : bus.cmd_x;
            w_cur_y = (bus.cmd_y > YMAX) ? YMAX : bus.cmd_y;
          end
          OP_MOVE: begin
            w_cur_x = (bus.cmd_dir == DIR_RIGHT) ? ((r_cur_x == XMAX) ? '0 : r_cur_x + 1'b1) :
                      (bus.cmd_dir == DIR_LEFT)  ? ((r_cur_x == '0) ? XMAX : r_cur_x - 1'b1) : r_cur_x;
            w_cur_y = (bus.cmd_dir == DIR_DOWN)  ? ((r_cur_y == YMAX) ? '0 : r_cur_y + 1'b1) :
                      (bus.cmd_dir == DIR_UP)    ? ((r_cur_y == '0) ? YMAX : r_cur_y - 1'b1) : r_cur_y;
          end
          OP_WRITE: begin
            w_state   = ST_WRITE;
            w_wr_en   = 1'b1;
            w_wr_x    = r_cur_x;
            w_wr_y    = r_cur_y;
            w_wr_data = bus.cmd_data;
          end
`ifdef GRID_FILL_EN
          OP_FILL: begin
            w_state   = ST_FILL;
            w_wr_en   = 1'b1;
            w_wr_x    = '0;
            w_wr_y    = '0;
            w_wr_data = bus.cmd_data;
          end
`endif
          default: ;
        endcase
      end
      ST_WRITE: if (bus.wr_ready) begin
        w_state = ST_IDLE;
        w_wr_en = 1'b0;
      end
`ifdef GRID_FILL_EN
      // the write address doubles as the sweep counter, X fastest
      ST_FILL: if (bus.wr_ready) begin
        if (r_wr_x == XMAX && r_wr_y == YMAX) begin
          w_state     = ST_IDLE;
          w_wr_en     = 1'b0;
          w_fill_done = 1'b1;
        end else begin
          w_wr_x = (r_wr_x == XMAX) ? '0 : r_wr_x + 1'b1;
          w_wr_y = (r_wr_x == XMAX) ? r_wr_y + 1'b1 : r_wr_y;
        end
      end
`endif
      default: w_state = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cur_x   <= '0;
      r_cur_y   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_x    <= '0;
      r_wr_y    <= '0;
      r_wr_data <= '0;
      r_pix_x   <= PW'(ORG_X);
      r_pix_y   <= PW'(ORG_Y);
    end else begin
      r_state   <= w_state;
      r_cur_x   <= w_cur_x;
      r_cur_y   <= w_cur_y;
      r_wr_en   <= w_wr_en;
      r_wr_x    <= w_wr_x;
      r_wr_y    <= w_wr_y;
      r_wr_data <= w_wr_data;
      r_pix_x   <= w_pix_x;
      r_pix_y   <= w_pix_y;
    end
  end
`ifdef GRID_FILL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fill_done <= 1'b0;
    else        r_fill_done <= w_fill_done;
  end
  assign o_fill_done = r_fill_done;
`else
  assign o_fill_done = 1'b0;
`endif
  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_grid_x = r_wr_x;
  assign bus.wr_grid_y = r_wr_y;
  assign bus.wr_data   = r_wr_data;
  assign o_cur_grid_x  = r_cur_x;
  assign o_cur_grid_y  = r_cur_y;
  assign o_cur_pix_x   = r_pix_x;
  assign o_cur_pix_y   = r_pix_y;
endmodule
